// File: rtl/scarv_cop_decode_q.sv
// scarv_cop_decode_q
//   Decoded-instruction queue for the SCARV ISE coprocessor. Each accepted
//   encoding is decoded once at push time and then stored as the raw word
//   plus every decoded field. mccr_en is sampled at push time as well.
//
//   Optional feature: define SCARV_COP_DECODE_Q_BYPASS_EN to forward a push
//   made into an empty queue (with out_ready high) straight to the outputs
//   in the same cycle. Without the macro, an entry reaches the outputs one
//   cycle after it is pushed.
//
//   ISE encoding layout (fields are extracted from fixed positions; their
//   meaning depends on the class):
//     [6:0]   major opcode, must be 7'b0001011
//     [31:28] class index 0..8 (one-hot on out_class); 9..15 is illegal
//             0 packed-arith, 1 twiddle, 2 load/store, 3 random, 4 move,
//             5 multi-precision, 6 bitwise, 7 permute, 8 scatter/gather
//     [27:24] subclass index (one-hot on out_subclass)
//     [14:12] pack width code: 0..4 = 1/2/4/8/16 elements (32..2-bit);
//             also the halfword index for load/store subclasses 2/3
//     [10:7]  crd (also crs3, the accumulate source); crd1/crd2 = even/odd pair
//     [18:15] crs1, [23:20] crs2, [11:7] rd, [19:15] rs1
//     [23:15] immediate, sign-extended; [21] wb_h, [22] wb_b
//   Move subclass 0 is the CPR-initialise instruction (out_cprs_init).

module scarv_cop_decode_q #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          g_clk,
    input  logic          g_reset,
    input  logic          flush,
    input  logic [7:0]    mccr_en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_encoded,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_encoded,
    output logic          out_exception,
    output logic [8:0]    out_class,
    output logic [15:0]   out_subclass,
    output logic          out_cprs_init,
    output logic [2:0]    out_pw,
    output logic [3:0]    out_crs1,
    output logic [3:0]    out_crs2,
    output logic [3:0]    out_crs3,
    output logic [3:0]    out_crd,
    output logic [3:0]    out_crd1,
    output logic [3:0]    out_crd2,
    output logic [4:0]    out_rd,
    output logic [4:0]    out_rs1,
    output logic [31:0]   out_imm,
    output logic          out_wb_h,
    output logic          out_wb_b,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [6:0] OPC_ISE      = 7'b0001011;
    localparam logic [3:0] CLS_PACKED   = 4'd0;
    localparam logic [3:0] CLS_LDST     = 4'd2;
    localparam logic [3:0] CLS_RANDOM   = 4'd3;
    localparam logic [3:0] CLS_MOVE     = 4'd4;
    localparam logic [3:0] CLS_MP       = 4'd5;
    localparam logic [3:0] CLS_PERMUTE  = 4'd7;
    localparam logic [3:0] CLS_SCATGATH = 4'd8;
    localparam logic [3:0] SUB_LDST_LH  = 4'd2;
    localparam logic [3:0] SUB_LDST_SH  = 4'd3;
    localparam logic [3:0] SUB_MOVE_INI = 4'd0;

    typedef struct packed {
        logic [31:0] enc;
        logic        exc;
        logic [8:0]  cls;
        logic [15:0] sub;
        logic        cprs_init;
        logic [2:0]  pw;
        logic [3:0]  crs1;
        logic [3:0]  crs2;
        logic [3:0]  crs3;
        logic [3:0]  crd;
        logic [3:0]  crd1;
        logic [3:0]  crd2;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] imm;
        logic        wb_h;
        logic        wb_b;
    } entry_t;

    // Storage and queue state.
    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Decode intermediates.
    logic [3:0] w_cls_idx;
    logic [3:0] w_sub_idx;
    logic [2:0] w_pw;
    logic       w_opc_bad;
    logic       w_hidx_bad;
    logic       w_pw_bad;
    logic       w_pw_en;
    logic       w_en_bad;
    entry_t     w_dec;

    // Handshake and head selection.
    logic       w_push;
    logic       w_pop;
    logic       w_wr;
    logic       w_rd;
    logic       w_empty;
    logic       w_bypass;
    entry_t     w_out;

    // Combinational ISE decode of the offered encoding, including feature gating.
    always_comb begin
        w_cls_idx  = in_encoded[31:28];
        w_sub_idx  = in_encoded[27:24];
        w_pw       = in_encoded[14:12];

        w_opc_bad  = (in_encoded[6:0] != OPC_ISE) || (w_cls_idx > CLS_SCATGATH);
        // Halfword loads/stores only address halfword 0 or 1 of a word.
        w_hidx_bad = (w_cls_idx == CLS_LDST) &&
                     ((w_sub_idx == SUB_LDST_LH) || (w_sub_idx == SUB_LDST_SH)) &&
                     (w_pw > 3'd1);
        w_pw_bad   = (w_cls_idx == CLS_PACKED) && (w_pw > 3'd4);

        // Codes 5..7 have no enable bit and are treated as disabled.
        w_pw_en = 1'b0;
        case (w_pw)
            3'd0:    w_pw_en = mccr_en[3];
            3'd1:    w_pw_en = mccr_en[4];
            3'd2:    w_pw_en = mccr_en[5];
            3'd3:    w_pw_en = mccr_en[6];
            3'd4:    w_pw_en = mccr_en[7];
            default: w_pw_en = 1'b0;
        endcase

        w_en_bad = ((w_cls_idx == CLS_RANDOM)   && !mccr_en[0]) ||
                   ((w_cls_idx == CLS_MP)       && !mccr_en[1]) ||
                   ((w_cls_idx == CLS_SCATGATH) && !mccr_en[2]) ||
                   (((w_cls_idx == CLS_PACKED) || (w_cls_idx == CLS_PERMUTE)) && !w_pw_en);

        w_dec           = '0;
        w_dec.enc       = in_encoded;
        w_dec.exc       = w_opc_bad || w_hidx_bad || w_pw_bad || w_en_bad;
        w_dec.cls       = 9'(1) << w_cls_idx;
        w_dec.sub       = 16'(1) << w_sub_idx;
        w_dec.cprs_init = (w_cls_idx == CLS_MOVE) && (w_sub_idx == SUB_MOVE_INI);
        w_dec.pw        = w_pw;
        w_dec.crs1      = in_encoded[18:15];
        w_dec.crs2      = in_encoded[23:20];
        w_dec.crs3      = in_encoded[10:7];
        w_dec.crd       = in_encoded[10:7];
        w_dec.crd1      = {in_encoded[10:8], 1'b0};
        w_dec.crd2      = {in_encoded[10:8], 1'b1};
        w_dec.rd        = in_encoded[11:7];
        w_dec.rs1       = in_encoded[19:15];
        w_dec.imm       = {{23{in_encoded[23]}}, in_encoded[23:15]};
        w_dec.wb_h      = in_encoded[21];
        w_dec.wb_b      = in_encoded[22];

        // A trapping entry must not look like any executable class downstream.
        if (w_dec.exc) begin
            w_dec.cls       = '0;
            w_dec.sub       = '0;
            w_dec.cprs_init = 1'b0;
        end
    end

    // Handshake: in_ready depends only on stored occupancy, never on a same-cycle pop.
    always_comb begin
        w_empty  = (r_count == '0);
        in_ready = (r_count != CW'(DEPTH));
        w_push   = in_valid && in_ready && !flush;
`ifdef SCARV_COP_DECODE_Q_BYPASS_EN
        w_bypass = w_push && w_empty && out_ready;
`else
        w_bypass = 1'b0;
`endif
        out_valid = !w_empty || w_bypass;
        w_pop     = out_valid && out_ready && !flush;
        // A bypassed entry is pushed and popped in one cycle without touching storage.
        w_wr      = w_push && !w_bypass;
        w_rd      = w_pop && !w_bypass;
    end

    // Head selection: stored head, bypassed decode, or all-zero when nothing is valid.
    always_comb begin
        w_out = '0;
        if (!w_empty) begin
            w_out = r_mem[r_rptr];
        end else if (w_bypass) begin
            w_out = w_dec;
        end
    end

    // Entry storage; contents are only observable through a valid head, so no reset.
    always_ff @(posedge g_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_dec;
        end
    end

    // Pointers and occupancy; flush and reset both empty the queue.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count         = r_count;
    assign out_encoded   = w_out.enc;
    assign out_exception = w_out.exc;
    assign out_class     = w_out.cls;
    assign out_subclass  = w_out.sub;
    assign out_cprs_init = w_out.cprs_init;
    assign out_pw        = w_out.pw;
    assign out_crs1      = w_out.crs1;
    assign out_crs2      = w_out.crs2;
    assign out_crs3      = w_out.crs3;
    assign out_crd       = w_out.crd;
    assign out_crd1      = w_out.crd1;
    assign out_crd2      = w_out.crd2;
    assign out_rd        = w_out.rd;
    assign out_rs1       = w_out.rs1;
    assign out_imm       = w_out.imm;
    assign out_wb_h      = w_out.wb_h;
    assign out_wb_b      = w_out.wb_b;

endmodule

// File: tb/tb_scarv_cop_decode_q.sv
// Bench for scarv_cop_decode_q: directed vectors, a queue-based reference
// model checked every cycle, and literal expectations for key scenarios.

module tb_scarv_cop_decode_q;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] enc;
        logic        exc;
        logic [8:0]  cls;
        logic [15:0] sub;
        logic        cprs_init;
        logic [2:0]  pw;
        logic [3:0]  crs1;
        logic [3:0]  crs2;
        logic [3:0]  crs3;
        logic [3:0]  crd;
        logic [3:0]  crd1;
        logic [3:0]  crd2;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] imm;
        logic        wb_h;
        logic        wb_b;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [7:0]    mccr_en = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_encoded = 32'h0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_encoded;
    logic          out_exception;
    logic [8:0]    out_class;
    logic [15:0]   out_subclass;
    logic          out_cprs_init;
    logic [2:0]    out_pw;
    logic [3:0]    out_crs1, out_crs2, out_crs3, out_crd, out_crd1, out_crd2;
    logic [4:0]    out_rd, out_rs1;
    logic [31:0]   out_imm;
    logic          out_wb_h, out_wb_b;
    logic [CW-1:0] count;

    int n_total = 0;
    int n_bad   = 0;
    exp_t q[$];

    scarv_cop_decode_q #(.DEPTH(DEPTH)) dut (
        .g_clk        (clk),
        .g_reset      (rst),
        .flush        (flush),
        .mccr_en      (mccr_en),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_encoded   (in_encoded),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_encoded  (out_encoded),
        .out_exception(out_exception),
        .out_class    (out_class),
        .out_subclass (out_subclass),
        .out_cprs_init(out_cprs_init),
        .out_pw       (out_pw),
        .out_crs1     (out_crs1),
        .out_crs2     (out_crs2),
        .out_crs3     (out_crs3),
        .out_crd      (out_crd),
        .out_crd1     (out_crd1),
        .out_crd2     (out_crd2),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_imm      (out_imm),
        .out_wb_h     (out_wb_h),
        .out_wb_b     (out_wb_b),
        .count        (count)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference decode: what the stored entry must contain for an encoding and enables.
    function automatic exp_t dm(input logic [31:0] e, input logic [7:0] m);
        exp_t r;
        int cls, sub, pw, crd, v;
        bit exc, pw_on;
        cls = int'(e[31:28]);
        sub = int'(e[27:24]);
        pw  = int'(e[14:12]);
        crd = int'(e[10:7]);
        exc = (e[6:0] != 7'h0B) || (cls > 8);
        if (cls == 2 && (sub == 2 || sub == 3) && pw >= 2) exc = 1'b1;
        if (cls == 0 && pw > 4) exc = 1'b1;
        if (cls == 3 && !m[0]) exc = 1'b1;
        if (cls == 5 && !m[1]) exc = 1'b1;
        if (cls == 8 && !m[2]) exc = 1'b1;
        pw_on = (pw <= 4) && (((m >> (3 + pw)) & 8'd1) != 8'd0);
        if ((cls == 0 || cls == 7) && !pw_on) exc = 1'b1;
        r.enc       = e;
        r.exc       = exc;
        r.cls       = exc ? 9'd0 : 9'(1 << cls);
        r.sub       = exc ? 16'd0 : 16'(1 << sub);
        r.cprs_init = !exc && cls == 4 && sub == 0;
        r.pw        = e[14:12];
        r.crs1      = e[18:15];
        r.crs2      = e[23:20];
        r.crs3      = 4'(crd);
        r.crd       = 4'(crd);
        r.crd1      = 4'((crd / 2) * 2);
        r.crd2      = 4'((crd / 2) * 2 + 1);
        r.rd        = e[11:7];
        r.rs1       = e[19:15];
        v = int'(e[23:15]);
        if (v >= 256) v -= 512;
        r.imm       = 32'(v);
        r.wb_h      = e[21];
        r.wb_b      = e[22];
        return r;
    endfunction

    // Model state update on the same edge the DUT uses.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            bit push, pop, byp;
            byp = 1'b0;
`ifdef SCARV_COP_DECODE_Q_BYPASS_EN
            byp = in_valid && !flush && out_ready && (q.size() == 0);
`endif
            push = in_valid && (q.size() < DEPTH) && !flush;
            pop  = (q.size() > 0) && out_ready && !flush;
            if (flush) begin
                q.delete();
            end else if (!byp) begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(dm(in_encoded, mccr_en));
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        exp_t h, a;
        bit v;
        v = (q.size() != 0);
        h = '0;
        if (v) h = q[0];
`ifdef SCARV_COP_DECODE_Q_BYPASS_EN
        else if (in_valid && out_ready && !flush && !rst) begin
            v = 1'b1;
            h = dm(in_encoded, mccr_en);
        end
`endif
        a = {out_encoded, out_exception, out_class, out_subclass, out_cprs_init, out_pw,
             out_crs1, out_crs2, out_crs3, out_crd, out_crd1, out_crd2, out_rd, out_rs1,
             out_imm, out_wb_h, out_wb_b};
        chk("cyc_out_valid", out_valid, v);
        chk("cyc_count", count, q.size());
        chk("cyc_in_ready", in_ready, q.size() != DEPTH);
        chk("cyc_head", a, h);
    end

    task automatic step(input logic v, input logic [31:0] e, input logic [7:0] m,
                        input logic r, input logic f);
        in_valid = v; in_encoded = e; mccr_en = m; out_ready = r; flush = f;
        @(posedge clk); #1;
    endtask

    localparam logic [31:0] ENC_MP = 32'h5000000B;

    logic [31:0] tv_enc [13];
    logic [7:0]  tv_m   [13];

    initial begin
        tv_enc[0]  = 32'h3000000B; tv_m[0]  = 8'hFE;  // random, disabled
        tv_enc[1]  = 32'h3000000B; tv_m[1]  = 8'hFF;
        tv_enc[2]  = 32'h8000000B; tv_m[2]  = 8'hFB;  // scatter/gather, disabled
        tv_enc[3]  = 32'h0000500B; tv_m[3]  = 8'hFF;  // packed, pw code 5
        tv_enc[4]  = 32'h0000200B; tv_m[4]  = 8'hDF;  // packed 8-bit, P8 off
        tv_enc[5]  = 32'h7000000B; tv_m[5]  = 8'hF7;  // permute 32-bit, P32 off
        tv_enc[6]  = 32'h7000400B; tv_m[6]  = 8'hFF;
        tv_enc[7]  = 32'h2200200B; tv_m[7]  = 8'hFF;  // halfword index 2
        tv_enc[8]  = 32'h2300100B; tv_m[8]  = 8'hFF;
        tv_enc[9]  = 32'h9000000B; tv_m[9]  = 8'hFF;  // class 9
        tv_enc[10] = 32'h1000000F; tv_m[10] = 8'hFF;  // wrong opcode
        tv_enc[11] = 32'hF5FFFF8B; tv_m[11] = 8'hFF;
        tv_enc[12] = 32'h5A3CF78B; tv_m[12] = 8'hFF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_encoded", out_encoded, 0);
        rst = 1'b0;
        step(0, 32'h0, 8'hFF, 0, 0);

        // Literal pins on the reference decode.
        chk("mdl_pw5", dm(32'h0000500B, 8'hFF).exc, 1);
        chk("mdl_sh1", dm(32'h2300100B, 8'hFF).exc, 0);
        chk("mdl_perm_cls", dm(32'h7000400B, 8'hFF).cls, 9'h080);

        // Invalid opcode into an empty queue.
        step(1, 32'h0, 8'hFF, 0, 0);
        chk("inv_out_valid", out_valid, 1);
        chk("inv_exception", out_exception, 1);
        chk("inv_class", out_class, 0);
        chk("inv_count", count, 1);
        step(0, 32'h0, 8'hFF, 1, 0);
        chk("inv_drained", count, 0);

        // MP class gated by mccr_en[1].
        step(1, ENC_MP, 8'hFD, 0, 0);
        chk("mp_off_exc", out_exception, 1);
        chk("mp_off_class", out_class, 0);
        step(0, 32'h0, 8'hFF, 1, 0);
        step(1, ENC_MP, 8'hFF, 0, 0);
        chk("mp_on_exc", out_exception, 0);
        chk("mp_on_class", out_class, 9'h020);
        step(0, 32'h0, 8'hFF, 1, 0);

        // Field extraction on a bitwise instruction.
        step(1, 32'h6123458B, 8'hFF, 0, 0);
        chk("fld_class", out_class, 9'h040);
        chk("fld_sub", out_subclass, 16'h0002);
        chk("fld_crd", out_crd, 4'hB);
        chk("fld_crd1", out_crd1, 4'hA);
        chk("fld_crs1", out_crs1, 4'h6);
        chk("fld_crs2", out_crs2, 4'h2);
        chk("fld_pw", out_pw, 3'h4);
        chk("fld_rd", out_rd, 5'h0B);
        chk("fld_imm", out_imm, 32'h46);
        step(0, 32'h0, 8'hFF, 1, 0);

        // Fill to capacity with out_ready low; the fifth push is refused.
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h6000000B + (i << 16), 8'hFF, 0, 0);
            if (i == 3) chk("full_in_ready", in_ready, 0);
        end
        chk("full_count", count, 4);
        chk("full_head", out_encoded, 32'h6000000B);

        // Push and pop together while full: only the pop happens.
        step(1, 32'h6AAA000B, 8'hFF, 1, 0);
        chk("fullpp_count", count, 3);
        chk("fullpp_in_ready", in_ready, 1);
        chk("fullpp_head", out_encoded, 32'h6001000B);

        // Flush with a concurrent push.
        step(1, 32'h6BBB000B, 8'hFF, 0, 1);
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        step(0, 32'h0, 8'hFF, 0, 0);
        chk("flush_lost", out_valid, 0);

        // Ten push/pop pairs to wrap the pointers.
        step(1, 32'h4000000B, 8'hFF, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            chk("wrap_order", out_encoded, 32'h4000000B + ((i - 1) << 16));
            step(1, 32'h4000000B + (i << 16), 8'hFF, 1, 0);
        end
        chk("wrap_last", out_encoded, 32'h400A000B);
        chk("wrap_cprs_init", out_cprs_init, 1);
        step(0, 32'h0, 8'hFF, 1, 0);

        // Mixed legal and trapping encodings with a varying consumer.
        for (int i = 0; i < 13; i++) begin
            step(1, tv_enc[i], tv_m[i], (i % 3) != 0, 0);
        end
        repeat (DEPTH + 1) step(0, 32'h0, 8'hFF, 1, 0);

        // Reset in the middle of operation.
        step(1, 32'h6C00000B, 8'hFF, 0, 0);
        step(1, 32'h6D00000B, 8'hFF, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst_count", count, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_out_encoded", out_encoded, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 32'h6E00000B, 8'hFF, 0, 0);
        chk("mrst_head", out_encoded, 32'h6E00000B);
        chk("mrst_count1", count, 1);
        step(0, 32'h0, 8'hFF, 1, 0);
        step(0, 32'h0, 8'hFF, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
